// File: rtl/connect_pkg.sv
// Shared definitions for the Connect-N engine.
//   state_t      : controller states
//   WIN_*        : encoding of the winner output
//   DIR_DR/DIR_DC: row/column step for the four scan directions
//                  d0 horizontal, d1 vertical, d2 rising diagonal, d3 falling diagonal
//   cell_index   : flat bitmap index of (row, col), row 0 = bottom
package connect_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        RESOLVE = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_RED    = 2'b01;
    localparam logic [1:0] WIN_YELLOW = 2'b10;
    localparam logic [1:0] WIN_DRAW   = 2'b11;

    localparam int DIR_DR [4] = '{0, 1, 1,  1};
    localparam int DIR_DC [4] = '{1, 0, 1, -1};

    function automatic int cell_index(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/connect_win_scan.sv
// Sequential win scan around the last placed piece.
// Walks four directions, one cell per cycle, offsets -(WIN_LEN-1)..+(WIN_LEN-1)
// along each, counting contiguous cells owned by the mover.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   abort      : drops any scan in progress (board clear)
//   start      : begins a new scan on the next cycle
//   row, col   : placed cell, held stable by the caller while the scan runs
//   mover      : bitmap of the player who just moved
//   done       : high in the final scan cycle (win found or all cells walked)
//   win        : qualifies done; a run of WIN_LEN was found
//   dir, k     : direction and offset at which the run completed
module connect_win_scan
    import connect_pkg::*;
#(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4,
    parameter int RW      = $clog2(ROWS + 1),
    parameter int CLW     = $clog2(COLS),
    parameter int CW      = $clog2((ROWS > COLS) ? ROWS : COLS) + 2
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   abort,
    input  logic                   start,
    input  logic [RW-1:0]          row,
    input  logic [CLW-1:0]         col,
    input  logic [ROWS*COLS-1:0]   mover,
    output logic                   done,
    output logic                   win,
    output logic [1:0]             dir,
    output logic signed [CW-1:0]   k
);

    localparam int BW  = ROWS * COLS;
    localparam int RNW = $clog2(WIN_LEN + 1);
    localparam logic signed [CW-1:0] K_MIN   = CW'(1 - WIN_LEN);
    localparam logic signed [CW-1:0] K_MAX   = CW'(WIN_LEN - 1);
    localparam logic [RNW-1:0]       RUN_WIN = RNW'(WIN_LEN);
    localparam logic [BW-1:0]        ONE     = BW'(1);

    logic                 active;
    logic [1:0]           dir_q;
    logic signed [CW-1:0] k_q;
    logic [RNW-1:0]       run_q;
    logic [RNW-1:0]       run_next;
    logic                 hit;

    always_comb begin
        int r;
        int c;
        r   = int'(row) + int'(k_q) * DIR_DR[dir_q];
        c   = int'(col) + int'(k_q) * DIR_DC[dir_q];
        hit = 1'b0;
        // bounds are tested before the bitmap is touched
        if (r >= 0 && r < ROWS && c >= 0 && c < COLS)
            hit = |(mover & (ONE << cell_index(r, c, COLS)));
        run_next = hit ? run_q + 1'b1 : '0;
        win      = active && (run_next == RUN_WIN);
        done     = active && (win || (dir_q == 2'd3 && k_q == K_MAX));
    end

    // On completion dir_q/k_q are left where the run ended; they are the
    // latched result until the next start.
    always_ff @(posedge clk) begin
        if (!reset || abort) begin
            active <= 1'b0;
            dir_q  <= 2'd0;
            k_q    <= K_MIN;
            run_q  <= '0;
        end else if (start) begin
            active <= 1'b1;
            dir_q  <= 2'd0;
            k_q    <= K_MIN;
            run_q  <= '0;
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
            end else if (k_q == K_MAX) begin
                dir_q <= dir_q + 2'd1;
                k_q   <= K_MIN;
                run_q <= '0;
            end else begin
                k_q   <= k_q + CW'(1);
                run_q <= run_next;
            end
        end
    end

    assign dir = dir_q;
    assign k   = k_q;

endmodule

// File: rtl/connect_n_engine.sv
// Connect-N game engine: column drops with gravity, turn alternation,
// sequential win scan, win/draw resolution and winning-run mask.
//
// state   | meaning
// IDLE    | waiting for a column request
// CHECK   | win scan around the piece just placed
// RESOLVE | one cycle: declare win/draw or pass the turn
// OVER    | game finished, requests ignored until new_game/reset
//
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   col_sel           : requested column
//   place_req         : request level, rising edge = one request
//   new_game          : synchronous board clear
//   red_player        : red occupancy, bit row*COLS+col
//   yellow_player     : yellow occupancy, same indexing
//   turn_red          : red to move
//   valid_move        : one-cycle pulse, piece placed
//   invalid_move      : one-cycle pulse, request rejected
//   busy              : CHECK or RESOLVE
//   game_over         : OVER
//   winner            : 00 none, 01 red, 10 yellow, 11 draw
//   win_mask          : cells of the winning run
module connect_n_engine
    import connect_pkg::*;
#(
    parameter int ROWS      = 6,
    parameter int COLS      = 7,
    parameter int WIN_LEN   = 4,
    parameter int FIRST_RED = 1
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [$clog2(COLS)-1:0]   col_sel,
    input  logic                      place_req,
    input  logic                      new_game,
    output logic [ROWS*COLS-1:0]      red_player,
    output logic [ROWS*COLS-1:0]      yellow_player,
    output logic                      turn_red,
    output logic                      valid_move,
    output logic                      invalid_move,
    output logic                      busy,
    output logic                      game_over,
    output logic [1:0]                winner,
    output logic [ROWS*COLS-1:0]      win_mask
);

    localparam int BW  = ROWS * COLS;
    localparam int RW  = $clog2(ROWS + 1);
    localparam int CLW = $clog2(COLS);
    localparam int CW  = $clog2((ROWS > COLS) ? ROWS : COLS) + 2;
    localparam int PW  = $clog2(BW + 1);
    localparam logic [RW-1:0] FULL_COL   = RW'(ROWS);
    localparam logic [PW-1:0] FULL_BOARD = PW'(BW);
    localparam logic [BW-1:0] ONE        = BW'(1);

    state_t               state;
    logic                 req_q;
    logic [RW-1:0]        height [COLS];
    logic [PW-1:0]        piece_count;
    logic [RW-1:0]        place_row;
    logic [CLW-1:0]       place_col;
    logic                 win_q;

    logic                 req_edge;
    logic                 col_ok;
    logic [RW-1:0]        sel_height;
    logic                 accept;
    logic                 reject;
    logic [BW-1:0]        new_bit;
    logic [BW-1:0]        mask_dec;

    logic                 scan_done;
    logic                 scan_win;
    logic [1:0]           scan_dir;
    logic signed [CW-1:0] scan_k;

    always_comb begin
        req_edge   = place_req & ~req_q;
        col_ok     = int'(col_sel) < COLS;
        sel_height = col_ok ? height[col_sel] : '0;
        accept     = (state == IDLE) && req_edge && col_ok && (sel_height != FULL_COL);
        reject     = (state == IDLE) && req_edge && !(col_ok && (sel_height != FULL_COL));
        new_bit    = ONE << cell_index(int'(sel_height), int'(col_sel), COLS);
    end

    // Winning run occupies offsets k-WIN_LEN+1 .. k along the latched direction.
    always_comb begin
        int off;
        int r;
        int c;
        mask_dec = '0;
        off      = 0;
        r        = 0;
        c        = 0;
        for (int i = 0; i < WIN_LEN; i++) begin
            off = int'(scan_k) - (WIN_LEN - 1) + i;
            r   = int'(place_row) + off * DIR_DR[scan_dir];
            c   = int'(place_col) + off * DIR_DC[scan_dir];
            if (r >= 0 && r < ROWS && c >= 0 && c < COLS)
                mask_dec = mask_dec | (ONE << cell_index(r, c, COLS));
        end
    end

    connect_win_scan #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN),
        .RW      (RW),
        .CLW     (CLW),
        .CW      (CW)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .abort (new_game),
        .start (accept),
        .row   (place_row),
        .col   (place_col),
        .mover (turn_red ? red_player : yellow_player),
        .done  (scan_done),
        .win   (scan_win),
        .dir   (scan_dir),
        .k     (scan_k)
    );

    always_ff @(posedge clk) begin
        // new_game still tracks the request level so a held button
        // does not fire again once the clear is released
        if (!reset)
            req_q <= 1'b0;
        else
            req_q <= place_req;

        if (!reset || new_game) begin
            state         <= IDLE;
            red_player    <= '0;
            yellow_player <= '0;
            for (int i = 0; i < COLS; i++)
                height[i] <= '0;
            piece_count   <= '0;
            place_row     <= '0;
            place_col     <= '0;
            win_q         <= 1'b0;
            turn_red      <= (FIRST_RED != 0);
            valid_move    <= 1'b0;
            invalid_move  <= 1'b0;
            winner        <= WIN_NONE;
            win_mask      <= '0;
        end else begin
            valid_move   <= 1'b0;
            invalid_move <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (turn_red)
                            red_player <= red_player | new_bit;
                        else
                            yellow_player <= yellow_player | new_bit;
                        height[col_sel] <= sel_height + 1'b1;
                        piece_count     <= piece_count + 1'b1;
                        place_row       <= sel_height;
                        place_col       <= col_sel;
                        win_q           <= 1'b0;
                        valid_move      <= 1'b1;
                        state           <= CHECK;
                    end else if (reject) begin
                        invalid_move <= 1'b1;
                    end
                end
                CHECK: begin
                    if (scan_done) begin
                        win_q <= scan_win;
                        state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    if (win_q) begin
                        winner   <= turn_red ? WIN_RED : WIN_YELLOW;
                        win_mask <= mask_dec;
                        state    <= OVER;
                    end else if (piece_count == FULL_BOARD) begin
                        winner <= WIN_DRAW;
                        state  <= OVER;
                    end else begin
                        turn_red <= ~turn_red;
                        state    <= IDLE;
                    end
                end
                OVER: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == CHECK) || (state == RESOLVE);
    assign game_over = (state == OVER);

endmodule

// File: tb/tb_connect_n_engine.sv
// Directed bench for connect_n_engine: default 6x7/4 board plus a 2x2/3
// board for the draw case.
module tb_connect_n_engine;

    localparam int N = 42;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [2:0]   col_sel = 3'd0;
    logic         place_req = 1'b0;
    logic         new_game = 1'b0;
    logic [N-1:0] red_player, yellow_player, win_mask;
    logic         turn_red, valid_move, invalid_move, busy, game_over;
    logic [1:0]   winner;

    logic         s_col_sel = 1'b0;
    logic         s_place_req = 1'b0;
    logic         s_new_game = 1'b0;
    logic [3:0]   s_red, s_yellow, s_win_mask;
    logic         s_turn_red, s_valid, s_invalid, s_busy, s_game_over;
    logic [1:0]   s_winner;

    int vectors = 0;
    int miscompares = 0;
    int timeouts = 0;
    int vm_count = 0;

    connect_n_engine dut (
        .clk           (clk),
        .reset         (reset),
        .col_sel       (col_sel),
        .place_req     (place_req),
        .new_game      (new_game),
        .red_player    (red_player),
        .yellow_player (yellow_player),
        .turn_red      (turn_red),
        .valid_move    (valid_move),
        .invalid_move  (invalid_move),
        .busy          (busy),
        .game_over     (game_over),
        .winner        (winner),
        .win_mask      (win_mask)
    );

    connect_n_engine #(.ROWS(2), .COLS(2), .WIN_LEN(3), .FIRST_RED(1)) dut_s (
        .clk           (clk),
        .reset         (reset),
        .col_sel       (s_col_sel),
        .place_req     (s_place_req),
        .new_game      (s_new_game),
        .red_player    (s_red),
        .yellow_player (s_yellow),
        .turn_red      (s_turn_red),
        .valid_move    (s_valid),
        .invalid_move  (s_invalid),
        .busy          (s_busy),
        .game_over     (s_game_over),
        .winner        (s_winner),
        .win_mask      (s_win_mask)
    );

    always #20 clk = ~clk;

    always @(negedge clk) if (valid_move === 1'b1) vm_count++;

    task automatic start_game;
        @(negedge clk);
        new_game = 1'b1;
        s_new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        s_new_game = 1'b0;
    endtask

    // one-cycle request; returns the pulses seen and busy cycle count
    task automatic drop(input int col, output logic vm, output logic im, output int n);
        @(negedge clk);
        col_sel = 3'(col);
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        vm = valid_move;
        im = invalid_move;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (n >= 60) timeouts++;
    endtask

    task automatic drop_s(input int col, output logic vm, output int n);
        @(negedge clk);
        s_col_sel = 1'(col);
        s_place_req = 1'b1;
        @(negedge clk);
        s_place_req = 1'b0;
        vm = s_valid;
        n = 0;
        while (s_busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (n >= 60) timeouts++;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (red_player !== 42'd0) begin miscompares++; $display("FAIL reset_red got %h want 0", red_player); end
        vectors++; if (yellow_player !== 42'd0) begin miscompares++; $display("FAIL reset_yellow got %h want 0", yellow_player); end
        vectors++; if (turn_red !== 1'b1) begin miscompares++; $display("FAIL reset_turn got %b want 1", turn_red); end
        vectors++; if ({valid_move, invalid_move, busy, game_over} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_flags got %b want 0000", {valid_move, invalid_move, busy, game_over}); end
        vectors++; if (winner !== 2'b00) begin miscompares++; $display("FAIL reset_winner got %b want 00", winner); end
        vectors++; if (win_mask !== 42'd0) begin miscompares++; $display("FAIL reset_mask got %h want 0", win_mask); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vertical;
        int cols [7] = '{3, 0, 3, 0, 3, 0, 3};
        logic vm, im;
        int n;
        logic [N-1:0] er, ey;
        er = '0; ey = '0;
        er[3] = 1'b1; er[10] = 1'b1; er[17] = 1'b1; er[24] = 1'b1;
        ey[0] = 1'b1; ey[7] = 1'b1; ey[14] = 1'b1;
        start_game();
        for (int i = 0; i < 7; i++) begin
            drop(cols[i], vm, im, n);
            vectors++; if (vm !== 1'b1) begin miscompares++; $display("FAIL vert_valid move %0d got %b want 1", i, vm); end
            if (i == 0) begin
                vectors++; if (n !== 29) begin miscompares++; $display("FAIL vert_full_scan_cycles got %0d want 29", n); end
            end
        end
        vectors++; if (winner !== 2'b01) begin miscompares++; $display("FAIL vert_winner got %b want 01", winner); end
        vectors++; if (game_over !== 1'b1) begin miscompares++; $display("FAIL vert_game_over got %b want 1", game_over); end
        vectors++; if (win_mask !== er) begin miscompares++; $display("FAIL vert_mask got %h want %h", win_mask, er); end
        vectors++; if (yellow_player !== ey) begin miscompares++; $display("FAIL vert_yellow got %h want %h", yellow_player, ey); end
        drop(5, vm, im, n);
        vectors++; if ({vm, im} !== 2'b00) begin miscompares++; $display("FAIL vert_over_pulses got %b want 00", {vm, im}); end
        vectors++; if (red_player !== er) begin miscompares++; $display("FAIL vert_red_frozen got %h want %h", red_player, er); end
        vectors++; if (turn_red !== 1'b1) begin miscompares++; $display("FAIL vert_turn_frozen got %b want 1", turn_red); end
    endtask

    task automatic test_full_column;
        logic vm, im;
        int n;
        logic [N-1:0] er, ey;
        er = '0; ey = '0;
        er[2] = 1'b1; er[16] = 1'b1; er[30] = 1'b1;
        ey[9] = 1'b1; ey[23] = 1'b1; ey[37] = 1'b1;
        start_game();
        for (int i = 0; i < 6; i++) begin
            drop(2, vm, im, n);
            vectors++; if (vm !== 1'b1) begin miscompares++; $display("FAIL fill_valid drop %0d got %b want 1", i, vm); end
        end
        drop(2, vm, im, n);
        vectors++; if ({vm, im} !== 2'b01) begin miscompares++; $display("FAIL full_col_pulses got %b want 01", {vm, im}); end
        vectors++; if (red_player !== er) begin miscompares++; $display("FAIL full_col_red got %h want %h", red_player, er); end
        vectors++; if (yellow_player !== ey) begin miscompares++; $display("FAIL full_col_yellow got %h want %h", yellow_player, ey); end
        vectors++; if (turn_red !== 1'b1) begin miscompares++; $display("FAIL full_col_turn got %b want 1", turn_red); end
        @(negedge clk);
        vectors++; if (invalid_move !== 1'b0) begin miscompares++; $display("FAIL invalid_width got %b want 0", invalid_move); end
        drop(7, vm, im, n);
        vectors++; if ({vm, im} !== 2'b01) begin miscompares++; $display("FAIL col7_pulses got %b want 01", {vm, im}); end
        vectors++; if (red_player !== er) begin miscompares++; $display("FAIL col7_red got %h want %h", red_player, er); end
    endtask

    task automatic test_diagonal;
        int cols [11] = '{0, 1, 1, 2, 3, 2, 2, 3, 3, 5, 3};
        logic vm, im;
        int n;
        logic [N-1:0] em;
        em = '0;
        em[0] = 1'b1; em[8] = 1'b1; em[16] = 1'b1; em[24] = 1'b1;
        start_game();
        for (int i = 0; i < 11; i++) begin
            drop(cols[i], vm, im, n);
            vectors++; if (vm !== 1'b1) begin miscompares++; $display("FAIL diag_valid move %0d got %b want 1", i, vm); end
        end
        vectors++; if (n !== 19) begin miscompares++; $display("FAIL diag_early_exit_cycles got %0d want 19", n); end
        vectors++; if (winner !== 2'b01) begin miscompares++; $display("FAIL diag_winner got %b want 01", winner); end
        vectors++; if (win_mask !== em) begin miscompares++; $display("FAIL diag_mask got %h want %h", win_mask, em); end
        vectors++; if (game_over !== 1'b1) begin miscompares++; $display("FAIL diag_game_over got %b want 1", game_over); end
    endtask

    task automatic test_draw;
        int cols [4] = '{0, 1, 1, 0};
        logic vm;
        int n;
        start_game();
        for (int i = 0; i < 4; i++) begin
            drop_s(cols[i], vm, n);
            vectors++; if (vm !== 1'b1) begin miscompares++; $display("FAIL draw_valid move %0d got %b want 1", i, vm); end
        end
        vectors++; if (n !== 21) begin miscompares++; $display("FAIL draw_scan_cycles got %0d want 21", n); end
        vectors++; if (s_winner !== 2'b11) begin miscompares++; $display("FAIL draw_winner got %b want 11", s_winner); end
        vectors++; if (s_win_mask !== 4'b0000) begin miscompares++; $display("FAIL draw_mask got %b want 0000", s_win_mask); end
        vectors++; if ({s_red, s_yellow} !== 8'b1001_0110) begin
            miscompares++; $display("FAIL draw_boards got %b want 10010110", {s_red, s_yellow}); end
        vectors++; if (s_game_over !== 1'b1) begin miscompares++; $display("FAIL draw_game_over got %b want 1", s_game_over); end
    endtask

    task automatic test_handshake;
        logic vm, im;
        int n;
        int v0;
        logic [N-1:0] er, ey;
        start_game();
        v0 = vm_count;
        @(negedge clk);
        col_sel = 3'd4;
        place_req = 1'b1;
        repeat (100) @(negedge clk);
        place_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin n++; @(negedge clk); end
        if (n >= 60) timeouts++;
        vectors++; if (vm_count - v0 !== 1) begin miscompares++; $display("FAIL held_req_pulses got %0d want 1", vm_count - v0); end
        // second request, plus one raised during CHECK which must vanish
        @(negedge clk);
        col_sel = 3'd4;
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL check_busy got %b want 1", busy); end
        col_sel = 3'd6;
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin n++; @(negedge clk); end
        if (n >= 60) timeouts++;
        repeat (3) @(negedge clk);
        er = '0; ey = '0;
        er[4] = 1'b1; ey[11] = 1'b1;
        vectors++; if (red_player !== er) begin miscompares++; $display("FAIL drop_in_check_red got %h want %h", red_player, er); end
        vectors++; if (yellow_player !== ey) begin miscompares++; $display("FAIL drop_in_check_yellow got %h want %h", yellow_player, ey); end
        vectors++; if (vm_count - v0 !== 2) begin miscompares++; $display("FAIL drop_in_check_pulses got %0d want 2", vm_count - v0); end
        // edge in the first IDLE cycle after RESOLVE
        drop(6, vm, im, n);
        col_sel = 3'd5;
        place_req = 1'b1;
        @(negedge clk);
        vectors++; if (valid_move !== 1'b1) begin miscompares++; $display("FAIL first_idle_edge got %b want 1", valid_move); end
        place_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin n++; @(negedge clk); end
        if (n >= 60) timeouts++;
        er[6] = 1'b1; ey[5] = 1'b1;
        vectors++; if ({red_player, yellow_player} !== {er, ey}) begin
            miscompares++; $display("FAIL first_idle_boards got %h/%h want %h/%h", red_player, yellow_player, er, ey); end
    endtask

    task automatic test_reset_mid;
        logic vm, im;
        int n;
        logic [N-1:0] er;
        start_game();
        drop(0, vm, im, n);
        @(negedge clk);
        col_sel = 3'd1;
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if ({busy, turn_red} !== 2'b10) begin miscompares++; $display("FAIL pre_reset_state got %b want 10", {busy, turn_red}); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        vectors++; if ({red_player, yellow_player} !== 84'd0) begin
            miscompares++; $display("FAIL mid_reset_boards got %h/%h want 0/0", red_player, yellow_player); end
        vectors++; if ({busy, game_over, turn_red, valid_move} !== 4'b0010) begin
            miscompares++; $display("FAIL mid_reset_flags got %b want 0010", {busy, game_over, turn_red, valid_move}); end
        drop(1, vm, im, n);
        er = '0; er[1] = 1'b1;
        vectors++; if (red_player !== er) begin miscompares++; $display("FAIL post_reset_drop got %h want %h", red_player, er); end
    endtask

    task automatic test_new_game_edge;
        logic vm, im;
        int n;
        drop(0, vm, im, n);
        @(negedge clk);
        col_sel = 3'd3;
        place_req = 1'b1;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        place_req = 1'b0;
        vectors++; if (valid_move !== 1'b0) begin miscompares++; $display("FAIL ng_edge_valid got %b want 0", valid_move); end
        vectors++; if ({red_player, yellow_player} !== 84'd0) begin
            miscompares++; $display("FAIL ng_edge_boards got %h/%h want 0/0", red_player, yellow_player); end
        vectors++; if ({busy, turn_red} !== 2'b01) begin miscompares++; $display("FAIL ng_edge_state got %b want 01", {busy, turn_red}); end
        vectors++; if (timeouts !== 0) begin miscompares++; $display("FAIL wait_timeouts got %0d want 0", timeouts); end
    endtask

    initial begin
        test_reset();
        test_vertical();
        test_full_column();
        test_diagonal();
        test_draw();
        test_handshake();
        test_reset_mid();
        test_new_game_edge();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
